dht_responder: RTL and testbench



---
 rtl/dht_pkg.sv | 33 +++
 rtl/dht_input_sync.sv | 21 ++
 rtl/dht_responder.sv | 122 ++++++++++++
 tb/tb_dht_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared constants for the DHT11 sensor-side responder: one-hot states,
// default 100 MHz timing, frame/counter widths and the checksum helper.
package dht_pkg;

  localparam int FRAME_W = 40;
  localparam int CNT_W   = 21;
  localparam int IDX_W   = 6;

  localparam int START_LOW_MIN_C = 1000000;
  localparam int RESP_DELAY_C    = 3000;
  localparam int RESP_LOW_C      = 8000;
  localparam int RESP_HIGH_C     = 8000;
  localparam int BIT_LOW_C       = 5000;
  localparam int BIT0_HIGH_C     = 2600;
  localparam int BIT1_HIGH_C     = 7000;

  typedef enum logic [8:0] {
    S_IDLE         = 9'b000000001,
    S_HOST_LOW     = 9'b000000010,
    S_WAIT_RELEASE = 9'b000000100,
    S_RESP_DELAY   = 9'b000001000,
    S_RESP_LO      = 9'b000010000,
    S_RESP_HI      = 9'b000100000,
    S_BIT_LO       = 9'b001000000,
    S_BIT_HI       = 9'b010000000,
    S_END_LO       = 9'b100000000
  } state_e;

  function automatic logic [7:0] checksum(input logic [31:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/dht_input_sync.sv
// Two-flop synchronizer for the open-drain data line; resets to the idle-high level.
module dht_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/dht_responder.sv
// DHT11 sensor emulator: qualifies the host start pulse, then sends preamble,
// 40 bits (frame[0] first) and the end pulse. Option: DHT_CHECKSUM_CORRUPT_EN.
import dht_pkg::*;

module dht_responder #(
  parameter int START_LOW_MIN = START_LOW_MIN_C,
  parameter int RESP_DELAY    = RESP_DELAY_C,
  parameter int RESP_LOW      = RESP_LOW_C,
  parameter int RESP_HIGH     = RESP_HIGH_C,
  parameter int BIT_LOW       = BIT_LOW_C,
  parameter int BIT0_HIGH     = BIT0_HIGH_C,
  parameter int BIT1_HIGH     = BIT1_HIGH_C
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         DTH,
  input  logic [31:0] sensor_data,
  output logic        busy,
  output logic        frame_done,
  output logic        start_seen
`ifdef DHT_CHECKSUM_CORRUPT_EN
  ,
  input  logic        corrupt_cksum
`endif
);

  // Terminal counts: a phase of N cycles ends when the counter shows N-1.
  localparam logic [CNT_W-1:0] T_START = CNT_W'(START_LOW_MIN - 1);
  localparam logic [CNT_W-1:0] T_RD    = CNT_W'(RESP_DELAY - 1);
  localparam logic [CNT_W-1:0] T_RL    = CNT_W'(RESP_LOW - 1);
  localparam logic [CNT_W-1:0] T_RH    = CNT_W'(RESP_HIGH - 1);
  localparam logic [CNT_W-1:0] T_BL    = CNT_W'(BIT_LOW - 1);
  localparam logic [CNT_W-1:0] T_B0    = CNT_W'(BIT0_HIGH - 1);
  localparam logic [CNT_W-1:0] T_B1    = CNT_W'(BIT1_HIGH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           cks;
  logic                 line_s;
  logic                 drive_low;

  dht_input_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (DTH),
    .q_o (line_s)
  );

`ifdef DHT_CHECKSUM_CORRUPT_EN
  assign cks = checksum(sensor_data) ^ {8{corrupt_cksum}};
`else
  assign cks = checksum(sensor_data);
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    start_seen = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:         if (!line_s) state_d = S_HOST_LOW;
      S_HOST_LOW: begin
        if (line_s) state_d = S_IDLE;
        else if (cnt_q >= T_START) begin
          start_seen = 1'b1;
          frame_d    = {sensor_data, cks};
          state_d    = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: if (line_s) state_d = S_RESP_DELAY;
      S_RESP_DELAY:   if (cnt_q == T_RD) state_d = S_RESP_LO;
      S_RESP_LO:      if (cnt_q == T_RL) state_d = S_RESP_HI;
      S_RESP_HI: begin
        if (cnt_q == T_RH) begin
          idx_d   = '0;
          state_d = S_BIT_LO;
        end
      end
      S_BIT_LO:       if (cnt_q == T_BL) state_d = S_BIT_HI;
      S_BIT_HI: begin
        if (cnt_q == (frame_q[idx_q] ? T_B1 : T_B0)) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == IDX_W'(FRAME_W - 1)) ? S_END_LO : S_BIT_LO;
        end
      end
      S_END_LO: begin
        if (cnt_q == T_BL) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default:        state_d = S_IDLE;
    endcase
    // Saturating phase timer, restarted on every state change.
    if (state_d != state_q) cnt_d = '0;
    else if (&cnt_q)        cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign busy      = !(state_q inside {S_IDLE, S_HOST_LOW});
  assign drive_low = state_q inside {S_RESP_LO, S_BIT_LO, S_END_LO};
  // Gated by rst so an asserted reset frees the line without waiting for a flop.
  assign DTH = (drive_low && !rst) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht_responder.sv
// Directed bench for dht_responder with scaled-down timing; decodes the line
// like a host reader and checks timing, frame contents, pulses and reset.
module tb_dht_responder;

  localparam int SLM = 100, RD = 30, RL = 80, RH = 80, BL = 50, B0 = 26, B1 = 70;
  localparam int HOLD = 180;
  localparam int LIM  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_low;
  logic [31:0] sensor_data;
  logic        busy, frame_done, start_seen;
  wire         DTH;
`ifdef DHT_CHECKSUM_CORRUPT_EN
  logic        corrupt_cksum = 1'b0;
`endif

  int total = 0, bad = 0;
  int ss_cnt = 0, fd_cnt = 0, dut_low_cnt = 0;

  always #5 clk = ~clk;

  pullup (DTH);
  assign DTH = host_low ? 1'b0 : 1'bz;

  dht_responder #(
    .START_LOW_MIN(SLM), .RESP_DELAY(RD), .RESP_LOW(RL), .RESP_HIGH(RH),
    .BIT_LOW(BL), .BIT0_HIGH(B0), .BIT1_HIGH(B1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DTH         (DTH),
    .sensor_data (sensor_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .start_seen  (start_seen)
`ifdef DHT_CHECKSUM_CORRUPT_EN
    ,
    .corrupt_cksum (corrupt_cksum)
`endif
  );

  always @(negedge clk) begin
    if (start_seen === 1'b1) ss_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (DTH === 1'b0 && !host_low) dut_low_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Host pulls low for HOLD cycles; returns cycles until start_seen.
  task automatic host_start(output int lat);
    host_low = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (start_seen !== 1'b1 && lat < 3 * SLM);
    if (lat < HOLD) repeat (HOLD - lat) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 1;
    @(negedge clk);
    while (DTH === lvl && n < LIM) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Decodes one frame from host release; stops at the first low sample of stop_bit.
  task automatic rx_frame(input int stop_bit, output logic [39:0] rx,
                          output int gap, output int rl, output int rh,
                          output int bad_low, output int endl);
    int n;
    rx = '0; bad_low = 0; endl = 0; rl = 0; rh = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (DTH !== 1'b0 && n < LIM);
    gap = n - 1;
    run_len(1'b0, rl);
    run_len(1'b1, rh);
    for (int i = 0; i < 40; i++) begin
      if (i == stop_bit) return;
      run_len(1'b0, n);
      if (n != BL) bad_low++;
      run_len(1'b1, n);
      rx[i] = (n > (B0 + B1) / 2);
    end
    run_len(1'b0, endl);
  endtask

  task automatic full_frame(input string tag, input logic [39:0] exp_frame);
    int lat, gap, rl, rh, bl_bad, endl, fd0;
    logic [39:0] rx;
    fd0 = fd_cnt;
    host_start(lat);
    chk_rng({tag, "_start_lat"}, lat, SLM, SLM + 4);
    chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
    sensor_data = ~sensor_data;
    rx_frame(-1, rx, gap, rl, rh, bl_bad, endl);
    chk_rng({tag, "_gap"}, gap, RD, RD + 4);
    chk({tag, "_resp_low"}, 64'(rl), 64'(RL));
    chk({tag, "_resp_high"}, 64'(rh), 64'(RH));
    chk({tag, "_bit_lows"}, 64'(bl_bad), 64'd0);
    chk({tag, "_frame"}, 64'(rx), 64'(exp_frame));
    chk({tag, "_cks_err"}, 64'(rx[7:0] != 8'(rx[39:32] + rx[31:24] + rx[23:16] + rx[15:8])),
        64'(exp_frame[7:0] != 8'(exp_frame[39:32] + exp_frame[31:24] + exp_frame[23:16] + exp_frame[15:8])));
    chk({tag, "_end_low"}, 64'(endl), 64'(BL));
    chk({tag, "_done_cnt"}, 64'(fd_cnt - fd0), 64'd1);
    chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ss0, fd0, low0, lat, n, exp_n, gap, rl, rh, bl_bad, endl;
    logic [39:0] rx, f;

    rst = 1'b1; host_low = 1'b0; sensor_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_line", 64'(DTH), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(start_seen), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Short host pulse is not a start request.
    ss0 = ss_cnt; low0 = dut_low_cnt;
    host_low = 1'b1;
    repeat (SLM / 2) @(negedge clk);
    host_low = 1'b0;
    repeat (SLM) @(negedge clk);
    chk("short_start", 64'(ss_cnt - ss0), 64'd0);
    chk("short_busy", 64'(busy), 64'd0);
    chk("short_drive", 64'(dut_low_cnt - low0), 64'd0);
    chk("short_idle", 64'(dut.state_q), 64'(dht_pkg::S_IDLE));

    // Data is inverted after start_seen to prove the snapshot holds.
    sensor_data = 32'h2300_1A00;
    full_frame("f1", 40'h2300_1A00_3D);
    repeat (10) @(negedge clk);

    sensor_data = 32'h3701_1905;
    full_frame("loop", 40'h3701_1905_56);
    repeat (10) @(negedge clk);

`ifdef DHT_CHECKSUM_CORRUPT_EN
    sensor_data = 32'h3701_1905;
    corrupt_cksum = 1'b1;
    full_frame("corrupt", 40'h3701_1905_A9);
    corrupt_cksum = 1'b0;
    repeat (10) @(negedge clk);
`endif

    // Reset in the low phase of bit 17.
    sensor_data = 32'h2300_1A00;
    host_start(lat);
    rx_frame(17, rx, gap, rl, rh, bl_bad, endl);
    chk("b17_low", 64'(DTH), 64'd0);
    chk("b17_prefix", 64'(rx[16:0]), 64'(17'h0_003D));
    rst = 1'b1;
    #1;
    chk("rst_mid_line", 64'(DTH), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sensor_data = 32'h2300_1A00;
    full_frame("after_rst", 40'h2300_1A00_3D);
    repeat (10) @(negedge clk);

    // Second start while busy is ignored; frame length is unchanged.
    sensor_data = 32'h3701_1905;
    f = 40'h3701_1905_56;
    exp_n = 2 + RD + RL + RH + 41 * BL + $countones(f) * B1 + (40 - $countones(f)) * B0;
    ss0 = ss_cnt; fd0 = fd_cnt;
    host_start(lat);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      host_low = (n >= 500 && n < 500 + HOLD);
    end while (frame_done !== 1'b1 && n < 3 * exp_n);
    host_low = 1'b0;
    chk("busy_len", 64'(n), 64'(exp_n));
    repeat (SLM + 50) @(negedge clk);
    chk("busy_start_cnt", 64'(ss_cnt - ss0), 64'd1);
    chk("busy_done_cnt", 64'(fd_cnt - fd0), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
